// File: rtl/regfile_dump_reader.sv
// Purpose: walks register addresses FIRST_REG..LAST_REG through a registered read port and streams (addr, data) pairs out.
// Latency: 3 cycles per word (fetch, capture, send); the first word is valid 3 cycles after start is sampled.
// Backpressure: the word is held in SEND while out_ready is low; each stalled cycle adds exactly one cycle.
module regfile_dump_reader #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
);

    // Walk bounds truncated to the pointer width, so LAST < FIRST wraps naturally.
    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(LAST_REG);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_CAPTURE = 3'd2,
        S_SEND    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W-1:0]  ptr;

    // State register; reset abandons any dump in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort outranks everything once a dump is running.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                state_nxt = abort ? S_IDLE : S_CAPTURE;
            end
            S_CAPTURE: begin
                state_nxt = abort ? S_IDLE : S_SEND;
            end
            S_SEND: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (out_ready) begin
                    state_nxt = (ptr == LAST) ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Status outputs decode state only, so no input reaches an output combinationally.
    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        out_valid = (state == S_SEND);
    end

    // Pointer and output word registers; the word is frozen for the whole SEND phase.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr      <= '0;
            out_addr <= '0;
            out_data <= '0;
        end else begin
            if (state == S_IDLE && start && !abort) begin
                ptr <= FIRST;
            end
            if (state == S_CAPTURE && !abort) begin
                out_addr <= ptr;
                out_data <= rf_data;
            end
            if (state == S_SEND && out_ready && !abort && ptr != LAST) begin
                ptr <= ptr + ADDR_W'(1);
            end
        end
    end

    assign rf_addr = ptr;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: a default-range instance and a wrapping-range (30..1) instance.
// A per-cycle timeline model predicts busy/done/valid/address/data from word counts and handshakes.
module tb_regfile_dump_reader;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        start_i [2];
    logic        abort_i [2];
    logic        ready_i [2];
    logic        busy_o  [2];
    logic        done_o  [2];
    logic        valid_o [2];
    logic [4:0]  raddr_o [2];
    logic [4:0]  oaddr_o [2];
    logic [31:0] odata_o [2];
    logic [31:0] rdata   [2];
    logic [31:0] mem     [32];

    int nvec = 0;
    int nmis = 0;

    regfile_dump_reader dut0 (
        .clock(clock), .reset(reset), .start(start_i[0]), .abort(abort_i[0]),
        .busy(busy_o[0]), .done(done_o[0]), .rf_addr(raddr_o[0]), .rf_data(rdata[0]),
        .out_valid(valid_o[0]), .out_ready(ready_i[0]), .out_addr(oaddr_o[0]), .out_data(odata_o[0])
    );

    regfile_dump_reader #(.FIRST_REG(30), .LAST_REG(1)) dut1 (
        .clock(clock), .reset(reset), .start(start_i[1]), .abort(abort_i[1]),
        .busy(busy_o[1]), .done(done_o[1]), .rf_addr(raddr_o[1]), .rf_data(rdata[1]),
        .out_valid(valid_o[1]), .out_ready(ready_i[1]), .out_addr(oaddr_o[1]), .out_data(odata_o[1])
    );

    // Register file read ports: one-cycle registered read latency.
    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) rdata[i] <= mem[raddr_o[i]];
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, want, $time);
        end
    endtask

    // Timeline model: per instance, whether a dump is active, the current cycle index since
    // the start edge, the cycle the pending word appears, the word index and the done cycle.
    bit          act     [2];
    int          t       [2];
    int          pres    [2];
    int          idx     [2];
    int          done_at [2];
    int          nw      [2] = '{32, 4};
    int          first   [2] = '{0, 30};
    // Observations used by the hand-computed checks.
    int          busy_cnt  [2];
    int          done_seen [2];
    int          done_rel  [2];
    int          stall_cnt [2];
    int          acc       [2];
    logic [31:0] first_d   [2];
    logic [31:0] last_d    [2];
    logic [4:0]  aq [$];
    bit          prev_stall [2];
    logic [4:0]  prev_a [2];
    logic [31:0] prev_d [2];
    logic [4:0]  ea;
    bit          ev;

    // Compare process: checks every output every cycle, then advances the model.
    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                chk("rst_busy", busy_o[i], 0);
                chk("rst_done", done_o[i], 0);
                chk("rst_valid", valid_o[i], 0);
                chk("rst_rf_addr", raddr_o[i], 0);
                chk("rst_out_addr", oaddr_o[i], 0);
                chk("rst_out_data", odata_o[i], 0);
                act[i] = 0;
                prev_stall[i] = 0;
            end else begin
                ev = act[i] && done_at[i] < 0 && t[i] >= pres[i];
                ea = 5'(first[i] + idx[i]);
                chk("busy", busy_o[i], act[i]);
                chk("done", done_o[i], act[i] && t[i] == done_at[i]);
                chk("out_valid", valid_o[i], ev);
                if (ev) begin
                    chk("out_addr", oaddr_o[i], ea);
                    chk("out_data", odata_o[i], mem[ea]);
                end
                if (act[i] && done_at[i] < 0) chk("rf_addr", raddr_o[i], ea);
                if (valid_o[i] && prev_stall[i]) begin
                    chk("stable_addr", oaddr_o[i], prev_a[i]);
                    chk("stable_data", odata_o[i], prev_d[i]);
                end
                prev_stall[i] = valid_o[i] && !ready_i[i];
                prev_a[i] = oaddr_o[i];
                prev_d[i] = odata_o[i];
                if (busy_o[i]) busy_cnt[i]++;
                if (done_o[i]) begin
                    done_seen[i]++;
                    done_rel[i] = t[i];
                end
                if (valid_o[i] && !ready_i[i]) stall_cnt[i]++;
                if (valid_o[i] && ready_i[i] && !abort_i[i]) begin
                    if (acc[i] == 0) first_d[i] = odata_o[i];
                    last_d[i] = odata_o[i];
                    if (i == 1) aq.push_back(oaddr_o[i]);
                    acc[i]++;
                end
                // Advance the model across the coming edge.
                if (!act[i]) begin
                    if (start_i[i] && !abort_i[i]) begin
                        act[i] = 1; t[i] = 1; pres[i] = 3; idx[i] = 0; done_at[i] = -1;
                    end
                end else if (abort_i[i] || t[i] == done_at[i]) begin
                    act[i] = 0;
                end else begin
                    if (ev && ready_i[i]) begin
                        if (idx[i] == nw[i] - 1) done_at[i] = t[i] + 1;
                        else begin
                            idx[i]++;
                            pres[i] = t[i] + 3;
                        end
                    end
                    t[i]++;
                end
            end
        end
    end

    task automatic clr(input int i);
        busy_cnt[i] = 0; done_seen[i] = 0; done_rel[i] = -1; stall_cnt[i] = 0; acc[i] = 0;
        first_d[i] = '0; last_d[i] = '0;
        if (i == 1) aq.delete();
    endtask

    // Pulse start for one cycle; returns in cycle 1 of the dump.
    task automatic go(input int i);
        @(posedge clock); #1 start_i[i] = 1;
        @(posedge clock); #1 start_i[i] = 0;
    endtask

    // Run until busy falls, optionally toggling out_ready 1,0,0,1,0,0,...
    task automatic wait_idle(input int i, input int budget, input bit toggle);
        int n = 0;
        int pc = 0;
        while (busy_o[i] !== 1'b0 && n < budget) begin
            if (toggle) begin
                ready_i[i] = (pc % 3 == 0);
                pc++;
            end
            @(posedge clock); #1;
            n++;
        end
        ready_i[i] = 1;
        chk("idle_reached", busy_o[i], 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1;
        for (int i = 0; i < 2; i++) begin
            start_i[i] = 0; abort_i[i] = 0; ready_i[i] = 1;
        end
        for (int j = 0; j < 32; j++) mem[j] = 32'hA5A5_0000 + j;
        #1 reset = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_busy_lit", busy_o[0], 0);
        chk("reset_data_lit", odata_o[0], 0);
        reset = 1;
        repeat (2) @(posedge clock);
        #1;

        // Full dump with out_ready held high.
        clr(0); go(0); wait_idle(0, 300, 0);
        chk("full_done_cycle", done_rel[0], 97);
        chk("full_busy_cycles", busy_cnt[0], 97);
        chk("full_done_count", done_seen[0], 1);
        chk("full_words", acc[0], 32);
        chk("full_first_data", first_d[0], 32'hA5A5_0000);
        chk("full_last_data", last_d[0], 32'hA5A5_001F);

        // Wrapping range 30..1.
        clr(1); go(1); wait_idle(1, 100, 0);
        chk("wrap_done_cycle", done_rel[1], 13);
        chk("wrap_words", acc[1], 4);
        chk("wrap_q_size", aq.size(), 4);
        if (aq.size() == 4) begin
            chk("wrap_addr0", aq[0], 30);
            chk("wrap_addr1", aq[1], 31);
            chk("wrap_addr2", aq[2], 0);
            chk("wrap_addr3", aq[3], 1);
        end
        chk("wrap_first_data", first_d[1], 32'hA5A5_001E);
        chk("wrap_last_data", last_d[1], 32'hA5A5_0001);

        // Backpressure: out_ready toggling.
        clr(0); go(0); wait_idle(0, 600, 1);
        chk("bp_stalls_seen", stall_cnt[0] > 0, 1);
        chk("bp_done_cycle", done_rel[0], 97 + stall_cnt[0]);
        chk("bp_words", acc[0], 32);
        chk("bp_done_count", done_seen[0], 1);

        // Abort in the SEND cycle of word 5 (cycle 18) with out_ready high.
        clr(0); go(0);
        repeat (17) @(posedge clock);
        #1 abort_i[0] = 1;
        @(posedge clock);
        #1 abort_i[0] = 0;
        chk("abort_busy", busy_o[0], 0);
        chk("abort_valid", valid_o[0], 0);
        chk("abort_words", acc[0], 5);
        chk("abort_no_done", done_seen[0], 0);
        clr(0); go(0); wait_idle(0, 300, 0);
        chk("restart_done_cycle", done_rel[0], 97);
        chk("restart_words", acc[0], 32);
        chk("restart_first_data", first_d[0], 32'hA5A5_0000);

        // start held high through the dump and its DONE cycle, dropped in IDLE.
        clr(0);
        @(posedge clock); #1 start_i[0] = 1;
        repeat (98) @(posedge clock);
        #1 start_i[0] = 0;
        repeat (4) @(posedge clock);
        #1;
        chk("hold_busy_cycles", busy_cnt[0], 97);
        chk("hold_done_count", done_seen[0], 1);
        chk("hold_words", acc[0], 32);
        chk("hold_idle", busy_o[0], 0);

        // Asynchronous reset in the CAPTURE cycle of word 2 (cycle 8).
        clr(0); go(0);
        repeat (7) @(posedge clock);
        #1;
        chk("pre_reset_data", odata_o[0], 32'hA5A5_0001);
        #1 reset = 0;
        #1;
        chk("areset_busy", busy_o[0], 0);
        chk("areset_valid", valid_o[0], 0);
        chk("areset_done", done_o[0], 0);
        chk("areset_rf_addr", raddr_o[0], 0);
        chk("areset_out_addr", oaddr_o[0], 0);
        chk("areset_out_data", odata_o[0], 0);
        @(posedge clock);
        #1 reset = 1;
        chk("areset_no_done", done_seen[0], 0);
        clr(0); go(0); wait_idle(0, 300, 0);
        chk("post_reset_done_cycle", done_rel[0], 97);
        chk("post_reset_words", acc[0], 32);

        repeat (2) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
